quad_encoder_gen: RTL



---
 rtl/quad_gen_pkg.sv | 17 +
 rtl/quad_phase_timer.sv | 43 ++++
 rtl/quad_encoder_gen.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/quad_gen_pkg.sv
// Shared types and helpers for the quadrature encoder emulator.
package quad_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  // Gray sequence 00 -> 10 -> 11 -> 01 as {a,b}; one bit changes per step.
  function automatic logic [1:0] idx_to_ab(input logic [1:0] idx);
    return {idx[1] ^ idx[0], idx[1]};
  endfunction

endpackage

// File: rtl/quad_phase_timer.sv
// Reloadable hold timer: tick at the end of each hold, optional glitch strobe
// for the cycle following this edge (QUAD_GEN_BOUNCE_EN).
module quad_phase_timer #(
  parameter int PHASE_CYCLES = 12
`ifdef QUAD_GEN_BOUNCE_EN
  , parameter int BOUNCE_CYCLES = 1
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
`ifdef QUAD_GEN_BOUNCE_EN
  output logic bounce_phase,
`endif
  output logic tick
);

  localparam int TW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(PHASE_CYCLES - 1);

  logic [TW-1:0] cnt;

  // Cleared while idle so the first tick lands on the first RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (!run)         cnt <= '0;
    else if (cnt == '0)    cnt <= RELOAD;
    else                   cnt <= cnt - TW'(1);
  end

  assign tick = run && (cnt == '0);

`ifdef QUAD_GEN_BOUNCE_EN
  int offset;

  // offset is the position within the hold of the cycle after this edge.
  always_comb begin
    offset       = PHASE_CYCLES - int'(cnt);
    bounce_phase = run && (cnt != '0) && offset[0] && (offset < 2 * BOUNCE_CYCLES);
  end
`endif

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: step commands in, A/B waveforms out.
// Optional contact bounce on every edge when QUAD_GEN_BOUNCE_EN is defined.
module quad_encoder_gen
  import quad_gen_pkg::*;
#(
  parameter int PHASE_CYCLES  = 12,
  parameter int CNT_W         = 16,
  parameter int BOUNCE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_abort,
  output logic             enc_a,
  output logic             enc_b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left,
  output state_t           fsm_state
);

  if (PHASE_CYCLES < 2) begin : g_chk_phase
    $error("PHASE_CYCLES must be at least 2");
  end
  if (BOUNCE_CYCLES < 0) begin : g_chk_bounce_sign
    $error("BOUNCE_CYCLES must not be negative");
  end
`ifdef QUAD_GEN_BOUNCE_EN
  if (PHASE_CYCLES <= 2 * BOUNCE_CYCLES + 1) begin : g_chk_bounce
    $error("PHASE_CYCLES must exceed 2*BOUNCE_CYCLES+1");
  end
`endif

  state_t           state, state_nxt;
  logic             dir;
  logic [1:0]       idx, idx_nxt;
  logic [CNT_W-1:0] steps_nxt;
  logic             tick, accept, step_now, finish;

  // Handshake: a command transfers on a cycle where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and inputs are sampled only on that cycle.
  assign accept   = cmd_valid && cmd_ready;
  assign step_now = tick && (steps_left != '0);
  assign finish   = tick && (steps_left == '0);
  assign fsm_state = state;

`ifdef QUAD_GEN_BOUNCE_EN
  logic       bounce_phase;
  logic [1:0] prev_idx;

  quad_phase_timer #(
    .PHASE_CYCLES (PHASE_CYCLES),
    .BOUNCE_CYCLES(BOUNCE_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (busy),
    .bounce_phase(bounce_phase),
    .tick        (tick)
  );
`else
  quad_phase_timer #(
    .PHASE_CYCLES(PHASE_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (busy),
    .tick (tick)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = RUN;
      RUN:     if (finish)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state == RUN);
  end

  always_comb begin
    idx_nxt = idx;
    if (step_now) idx_nxt = (dir == DIR_CW) ? idx + 2'd1 : idx - 2'd1;
  end

  // Abort collapses the remaining count to the detent in flight; a count of
  // 0 or 1 already means "finish this one", so abort leaves it alone.
  always_comb begin
    steps_nxt = steps_left;
    if (accept) begin
      steps_nxt = cmd_steps;
    end else if (busy) begin
      if (cmd_abort && (steps_left > CNT_W'(1))) steps_nxt = CNT_W'(1);
      if (step_now && (idx_nxt == 2'd0))         steps_nxt = steps_nxt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir        <= DIR_CW;
      idx        <= 2'd0;
      steps_left <= '0;
      done       <= 1'b0;
    end else begin
      if (accept) dir <= cmd_dir;
      idx        <= idx_nxt;
      steps_left <= steps_nxt;
      done       <= finish;
    end
  end

`ifdef QUAD_GEN_BOUNCE_EN
  // Glitch cycles show the previous phase, which differs only in the moved line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_idx       <= 2'd0;
      {enc_a, enc_b} <= 2'b00;
    end else begin
      if (step_now) prev_idx <= idx;
      {enc_a, enc_b} <= bounce_phase ? idx_to_ab(prev_idx) : idx_to_ab(idx_nxt);
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {enc_a, enc_b} <= 2'b00;
    else        {enc_a, enc_b} <= idx_to_ab(idx_nxt);
  end
`endif

endmodule
